// File: rtl/axi_tensor_wr_sink.sv
// AXI4 write-only sink that stores 256-bit INCR bursts into a small result buffer.
// A single burst is outstanding at a time; a separate port reads the buffer back.
module axi_tensor_wr_sink #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [7:0]            axi_awlen,
  input  logic [2:0]            axi_awsize,
  input  logic [1:0]            axi_awburst,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [255:0]          wr_data,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [255:0]          rd_data,
  output logic                  burst_done,
  output logic [8:0]            beats_rcvd
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t         state_reg, state_next;
  logic           active_reg;
  logic [AW-1:0]  ptr_reg;
  logic [7:0]     len_reg;
  logic [8:0]     beats_reg;
  logic           error_reg;
  logic           inhibit_reg;
  logic [255:0]   mem [DEPTH];

  logic aw_hs, w_hs, attr_bad, beat_is_len, wlast_bad;
  logic unused_addr_bits;

  assign aw_hs       = axi_awvalid & axi_awready;
  assign w_hs        = axi_wvalid & axi_wready;
  assign attr_bad    = (axi_awsize != 3'b101) || (axi_awburst != 2'b01) || (axi_awaddr[4:0] != 5'd0);
  assign beat_is_len = (beats_reg == {1'b0, len_reg});
  assign wlast_bad   = axi_wlast ^ beat_is_len;
  assign burst_done  = axi_bvalid & axi_bready;
  assign beats_rcvd  = beats_reg;
  assign unused_addr_bits = ^axi_awaddr[ADDR_WIDTH-1:5+AW];

  // Handshake readies decode state only; active_reg keeps awready low until the first edge after reset.
  always_comb begin
    state_next  = state_reg;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    axi_bresp   = 2'b00;
    case (state_reg)
      IDLE: begin
        axi_awready = active_reg;
        if (axi_awvalid && active_reg) state_next = DATA;
      end
      DATA: begin
        axi_wready = 1'b1;
        if (axi_wvalid && (beat_is_len || axi_wlast)) state_next = RESP;
      end
      RESP: begin
        axi_bvalid = 1'b1;
        axi_bresp  = error_reg ? 2'b10 : 2'b00;
        if (axi_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      active_reg  <= 1'b0;
      ptr_reg     <= '0;
      len_reg     <= '0;
      beats_reg   <= '0;
      error_reg   <= 1'b0;
      inhibit_reg <= 1'b0;
    end else begin
      active_reg <= 1'b1;
      state_reg  <= state_next;
      if (aw_hs) begin
        ptr_reg     <= axi_awaddr[5 +: AW];
        len_reg     <= axi_awlen;
        beats_reg   <= '0;
        error_reg   <= attr_bad;
        inhibit_reg <= attr_bad;
      end
      if (w_hs) begin
        ptr_reg   <= ptr_reg + 1'b1;
        beats_reg <= beats_reg + 9'd1;
        if (wlast_bad) error_reg <= 1'b1;
      end
    end
  end

  // Buffer contents survive reset so a result can be read after an aborted burst.
  always_ff @(posedge clk) begin
    if (w_hs && !inhibit_reg) mem[ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_axi_tensor_wr_sink.sv
// Randomized bench for axi_tensor_wr_sink against a word-level buffer model.
module tb_axi_tensor_wr_sink;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         axi_awvalid, axi_awready;
  logic [31:0]  axi_awaddr;
  logic [7:0]   axi_awlen;
  logic [2:0]   axi_awsize;
  logic [1:0]   axi_awburst;
  logic         axi_wvalid, axi_wready;
  logic [255:0] wr_data;
  logic         axi_wlast;
  logic         axi_bvalid, axi_bready;
  logic [1:0]   axi_bresp;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [255:0] rd_data;
  logic         burst_done;
  logic [8:0]   beats_rcvd;

  int checks = 0;
  int failures = 0;

  logic [255:0] model_mem [64];
  bit           known [64];

  axi_tensor_wr_sink #(.ADDR_WIDTH(32), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .wr_data(wr_data), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .burst_done(burst_done), .beats_rcvd(beats_rcvd)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, axi_awready, 1'b0);
    check({tag, "_wready"}, axi_wready, 1'b0);
    check({tag, "_bvalid"}, axi_bvalid, 1'b0);
    check({tag, "_bresp"}, axi_bresp, 2'b00);
    check({tag, "_burst_done"}, burst_done, 1'b0);
    check({tag, "_beats_rcvd"}, beats_rcvd, 9'd0);
    check({tag, "_rd_data"}, rd_data, 256'd0);
  endtask

  task automatic read_word(input int idx);
    logic [255:0] first;
    if (!known[idx]) return;
    @(posedge clk); #1;
    rd_en = 1'b1; rd_addr = idx[5:0];
    @(posedge clk); #1;
    rd_en = 1'b0;
    @(negedge clk);
    check($sformatf("rd_w%0d", idx), rd_data, model_mem[idx]);
    first = rd_data;
    @(negedge clk);
    check($sformatf("rd_hold_w%0d", idx), rd_data, first);
  endtask

  // One AW + W + B transaction; abort_at >= 0 pulses reset before that beat.
  task automatic do_burst(input string name, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                          input int idle_pct, input int bready_dly, input bit rd_same,
                          input bit idx_data, input int abort_at);
    bit attr_bad, err;
    int end_beat, nbeats, n, idx;
    logic [5:0] ptr0;
    logic [255:0] d, old;
    bit old_known;
    attr_bad = (size != 3'b101) || (burst != 2'b01) || (addr[4:0] != 5'd0);
    end_beat = (wlast_at < len) ? wlast_at : len;
    nbeats   = end_beat + 1;
    err      = attr_bad || (wlast_at != len);
    ptr0     = addr[10:5];

    @(posedge clk); #1;
    axi_awaddr = addr; axi_awlen = len[7:0]; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi_awready && n < 64) begin @(posedge clk); #1; @(negedge clk); n++; end
    if (!axi_awready) begin
      check({name, "_aw_timeout"}, axi_awready, 1'b1);
      axi_awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    axi_awvalid = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #2;
        check_reset_outputs({name, "_midrst"});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check({name, "_awready_after_rst"}, axi_awready, 1'b1);
        return;
      end
      while ($urandom_range(99) < idle_pct) begin
        axi_wvalid = 1'b0;
        @(posedge clk); #1;
      end
      if (idx_data) d = 256'(i);
      else for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      idx = (ptr0 + i) % 64;
      axi_wvalid = 1'b1; wr_data = d; axi_wlast = (i == wlast_at);
      if (rd_same) begin rd_en = 1'b1; rd_addr = idx[5:0]; end
      n = 0;
      @(negedge clk);
      while (!axi_wready && n < 64) begin @(posedge clk); #1; @(negedge clk); n++; end
      if (!axi_wready) begin
        check({name, "_w_timeout"}, axi_wready, 1'b1);
        axi_wvalid = 1'b0; axi_wlast = 1'b0; rd_en = 1'b0;
        return;
      end
      @(posedge clk); #1;
      axi_wvalid = 1'b0; axi_wlast = 1'b0; rd_en = 1'b0;
      old = model_mem[idx];
      old_known = known[idx];
      if (!attr_bad) begin model_mem[idx] = d; known[idx] = 1'b1; end
      if (rd_same && old_known) begin
        @(negedge clk);
        check($sformatf("%s_rbw_w%0d", name, idx), rd_data, old);
        @(posedge clk); #1;
      end
    end

    n = 0;
    @(negedge clk);
    while (!axi_bvalid && n < 64) begin @(negedge clk); n++; end
    check({name, "_bvalid"}, axi_bvalid, 1'b1);
    if (!axi_bvalid) return;
    check({name, "_resp_readies"}, {axi_awready, axi_wready}, 2'b00);
    check({name, "_beats_rcvd"}, beats_rcvd, 9'(nbeats));
    for (int k = 0; k < bready_dly; k++) begin
      check({name, "_bvalid_hold"}, axi_bvalid, 1'b1);
      check({name, "_bresp_hold"}, axi_bresp, err ? 2'b10 : 2'b00);
      check({name, "_done_early"}, burst_done, 1'b0);
      @(negedge clk);
    end
    axi_bready = 1'b1;
    #1;
    check({name, "_bresp"}, axi_bresp, err ? 2'b10 : 2'b00);
    check({name, "_burst_done"}, burst_done, 1'b1);
    @(posedge clk); #1;
    axi_bready = 1'b0;
    @(negedge clk);
    check({name, "_done_pulse_end"}, {burst_done, axi_bvalid, axi_awready}, 3'b001);
    $display("burst %s addr=%0h len=%0d beats=%0d bresp_exp=%0d", name, addr, len, nbeats, err ? 2 : 0);
  endtask

  initial begin
    int word, len, wl;
    logic [2:0] sz;
    logic [1:0] bu;
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin known[i] = 1'b0; model_mem[i] = '0; end
    rst_n = 1'b0;
    axi_awvalid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 0; axi_awburst = 0;
    axi_wvalid = 0; wr_data = 0; axi_wlast = 0; axi_bready = 0; rd_en = 0; rd_addr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("awready_after_rst", axi_awready, 1'b1);

    do_burst("full32", 32'h0, 31, 3'b101, 2'b01, 31, 0, 0, 1'b0, 1'b1, -1);
    for (int i = 0; i < 32; i++) read_word(i);

    word = $urandom_range(63);
    do_burst("len16_bp", 32'(word * 32), 15, 3'b101, 2'b01, 15, 40, 5, 1'b0, 1'b0, -1);
    for (int i = 0; i < 16; i++) read_word((word + i) % 64);

    do_burst("early_wlast", 32'h0, 7, 3'b101, 2'b01, 3, 0, 1, 1'b0, 1'b0, -1);
    for (int i = 0; i < 8; i++) read_word(i);

    do_burst("wrap63", 32'h7E0, 3, 3'b101, 2'b01, 3, 20, 1, 1'b1, 1'b0, -1);
    read_word(63); read_word(0); read_word(1); read_word(2);

    do_burst("bad_size", 32'h0, 3, 3'b100, 2'b01, 3, 0, 2, 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) read_word(i);

    do_burst("rst_mid", 32'h0, 31, 3'b101, 2'b01, 31, 0, 0, 1'b0, 1'b0, 10);
    for (int i = 0; i < 32; i++) read_word(i);
    do_burst("after_rst", 32'h0, 7, 3'b101, 2'b01, 7, 10, 1, 1'b0, 1'b0, -1);

    for (int t = 0; t < 16; t++) begin
      len  = $urandom_range(20);
      a    = 32'($urandom_range(63) * 32);
      sz   = ($urandom_range(9) == 0) ? 3'b011 : 3'b101;
      bu   = ($urandom_range(9) == 0) ? 2'b10 : 2'b01;
      if ($urandom_range(9) == 0) a[4:0] = 5'h10;
      wl   = ($urandom_range(4) == 0) ? $urandom_range(len + 2) : len;
      do_burst($sformatf("rnd%0d", t), a, len, sz, bu, wl, $urandom_range(40),
               $urandom_range(4), 1'($urandom_range(1)), 1'b0, -1);
    end
    for (int i = 0; i < 64; i++) read_word(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_tensor_wr_sink.md
AXI_TENSOR_WR_SINK -- requirements
Module: axi_tensor_wr_sink

Interface
REQ-001 Parameters (name, default, meaning): ADDR_WIDTH, 32, AXI byte-address width; DEPTH, 64, number of 256-bit words in the result buffer (power of 2).
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock; all logic on rising edge.
REQ-003 rst_n, in, 1, asynchronous active-low reset.
REQ-004 axi_awvalid/axi_awready, in/out, 1/1, AW handshake; axi_awaddr, in, ADDR_WIDTH, burst start byte address; axi_awlen, in, 8, beats-1; axi_awsize, in, 3; axi_awburst, in, 2.
REQ-005 axi_wvalid/axi_wready, in/out, 1/1, W handshake; wr_data, in, 256, beat data; axi_wlast, in, 1, last beat marker.
REQ-006 axi_bvalid/axi_bready, out/in, 1/1, B handshake; axi_bresp, out, 2, OKAY 2'b00 or SLVERR 2'b10.
REQ-007 rd_en, in, 1, readback strobe; rd_addr, in, log2(DEPTH), word index; rd_data, out, 256, readback word.
REQ-008 burst_done, out, 1, one-cycle pulse on B handshake; beats_rcvd, out, 9, beats accepted in the current/last burst.

Function
REQ-009 FSM states SHALL be IDLE, DATA, RESP; single burst outstanding.
REQ-010 IDLE: axi_awready=1, axi_wready=0, axi_bvalid=0; on AW handshake latch ptr=awaddr[5+:log2(DEPTH)], len=awlen, clear beats_rcvd, clear error flag, go DATA next cycle.
REQ-011 AW attributes: awsize!=3'b101 or awburst!=2'b01 or awaddr[4:0]!=0 sets error flag and inhibits all buffer writes for that burst; data SHALL still be absorbed.
REQ-012 DATA: axi_wready=1, axi_awready=0; each W handshake writes wr_data to mem[ptr] (unless inhibited), ptr<=ptr+1 mod DEPTH, beats_rcvd<=beats_rcvd+1.
REQ-013 Burst end: W handshake with beats_rcvd==len or axi_wlast=1 SHALL move to RESP next cycle.
REQ-014 wlast mismatch: wlast=1 before beat len, or wlast=0 on beat len, sets error flag; the mismatched beat is still written.
REQ-015 RESP: axi_bvalid=1, axi_bresp=error?2'b10:2'b00, held stable until axi_bready; on B handshake burst_done=1 for that cycle, go IDLE.
REQ-016 B handshake and a new AW cannot occur in the same cycle (awready low in RESP); minimum AW-to-AW spacing = len+3 cycles with ready sinks.
REQ-017 Buffer pointer wrap past DEPTH-1 SHALL return to 0 silently, no error.
REQ-018 Readback: rd_en=1 registers mem[rd_addr] onto rd_data next cycle; rd_data holds when rd_en=0.
REQ-019 Same-cycle readback and write to one address SHALL return the old contents (read-before-write).
REQ-020 awready/wready SHALL be pure functions of state (no combinational path from valid inputs).

Reset
REQ-021 rst_n low SHALL immediately force IDLE, axi_awready=0 while low then 1 after release, axi_wready=0, axi_bvalid=0, axi_bresp=0, burst_done=0, beats_rcvd=0, rd_data=0, ptr=0, error=0.
REQ-022 Buffer contents SHALL NOT be reset; reset mid-burst abandons the burst with no B response, already-written words retained.

Verification
REQ-023 AW addr=0, len=31, size=5, burst=1; 32 beats data=beat index, wlast on beat 31 -> mem[0..31]=0..31, bresp=00, burst_done one pulse, beats_rcvd=32.
REQ-024 AW len=15, wvalid toggled randomly, bready delayed 5 cycles -> 16 words written in order, bvalid held 5 cycles, bresp=00.
REQ-025 AW len=7 but wlast on beat 3 -> RESP after 4 beats, bresp=10, mem[4..7] unchanged.
REQ-026 AW addr=0x7E0 (word 63), len=3 -> writes words 63,0,1,2, bresp=00.
REQ-027 AW size=3'b100, len=3 -> 4 beats absorbed, no buffer change, bresp=10; readback of word written same cycle returns old value.
REQ-028 rst_n pulsed low at beat 10 of a 32-beat burst -> outputs at reset values, mem[0..9] retained, next burst completes with bresp=00.
